lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer between the decode/control stage and the data-memory bus. It takes the decoded MemRead/MemWrite strobes, func3 and the computed address, and runs a req/gnt/rvalid handshake on the data bus. It stalls the pipeline until the access completes, then returns sign- or zero-extended load data. It also flags misaligned accesses, illegal func3 values and bus timeouts.

Parameters:
TIMEOUT, 255, max cycles spent in REQ or WAIT before aborting; counter width is clog2(TIMEOUT+1).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  load request from control unit; held stable while lsu_stall=1
mem_write  in  1  store request; held stable while lsu_stall=1
func3  in  3  load/store width code (RV32I encoding)
addr  in  32  effective byte address
wdata  in  32  store data from rs2
lsu_stall  out  1  freeze pipeline
load_valid  out  1  1-cycle pulse; load_data valid
load_data  out  32  extended load result
exc_valid  out  1  1-cycle exception pulse
exc_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal
dmem_req  out  1  bus request
dmem_we  out  1  1=store
dmem_be  out  4  byte enables
dmem_addr  out  32  word address, addr with bits [1:0] forced to 00
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data returned
dmem_rdata  in  32  load word

Behaviour:
- Reset (asynchronous, rst_n low, including mid-access): state IDLE, counter 0. All outputs are 0. A pending access is dropped with no exception.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, with mem_read or mem_write high, is the accept check:
  - Illegal: mem_read and mem_write both high, load func3 in {011,110,111}, or store func3 not in {000,001,010} -> exc_valid=1, cause=11, stay IDLE, lsu_stall=0.
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0 -> exc_valid=1, cause=01, stay IDLE, lsu_stall=0.
  - Otherwise lsu_stall=1. Register op, func3, addr[1:0], be, word address and replicated data. Go to REQ.
- REQ: dmem_req=1 with registered dmem_we, dmem_be, dmem_addr, dmem_wdata held constant; lsu_stall=1.
  - On dmem_gnt: a store goes to DONE; a load goes to WAIT.
  - The timeout counter increments each cycle in REQ.
- WAIT: dmem_req=0, lsu_stall=1. On dmem_rvalid, capture the extracted load value and go to DONE.
  - The counter restarts from 0 on entering WAIT.
- DONE: lsu_stall=0. For loads, load_valid=1 and load_data holds the result. Always goes to IDLE next cycle, so back-to-back accesses have a 1-cycle IDLE gap.
- Timeout: when the counter reaches TIMEOUT in REQ or WAIT, drop dmem_req, pulse exc_valid with cause=10, go to IDLE, lsu_stall=0.
- Ignored inputs: rvalid in IDLE, REQ or DONE; gnt outside REQ.
- Minimum latency from accept cycle T0 (gnt at T1):
  - Store: DONE at T2.
  - Load: rvalid at T2 gives DONE at T3.
- Byte enables:
  - sb: be = 0001 << addr[1:0].
  - sh: be = 0011 when addr[1]=0, else 1100.
  - sw: be = 1111.
- Store data: sb replicates wdata[7:0] to all 4 lanes; sh replicates wdata[15:0] to both halves.
- Load extract: lane selected by the registered addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes dmem_rdata through.
- load_data holds its value until the next capture.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants;
  - func3 constants (F3_LB..F3_LHU, F3_SB..F3_SW);
  - lsu_state_t enum {IDLE,REQ,WAIT,DONE};
  - lsu_exc_t enum {EXC_NONE,EXC_MISALIGN,EXC_TIMEOUT,EXC_ILLEGAL}.
- One combinational sub-module, lsu_lane_align: byte-enable generation, store replication and load extract/extend, reused by lsu_ctrl.

Test Plan:
- lw addr=0x100, gnt at T1, rvalid at T2 with rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, stall T0–T2, load_valid at T3, load_data=0xDEADBEEF.
- lb addr=0x203, rdata=0x80FFFFFF -> be=1000, load_data=0xFFFFFF80; same access as lbu -> 0x00000080.
- sh addr=0x302, wdata=0x1234ABCD, gnt delayed 3 cycles -> dmem_addr=0x300, be=1100, dmem_wdata=0xABCDABCD held stable, DONE 1 cycle after gnt, no load_valid.
- lw addr=0x101 -> exc_valid=1 with cause=01 the same cycle, dmem_req never asserts, lsu_stall=0; mem_read=mem_write=1 -> cause=11.
- Load with gnt but no rvalid, TIMEOUT=8 -> exc cause=10 after 8 WAIT cycles, return to IDLE, no load_valid; gnt never arriving gives the same result from REQ.
- rst_n pulled low while in WAIT -> all outputs 0 immediately; a late rvalid after reset is ignored; next lw completes normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I memory-access definitions: opcodes, func3 width codes and the
// state / exception encodings used by the load/store sequencer.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_TIMEOUT  = 2'b10,
        EXC_ILLEGAL  = 2'b11
    } lsu_exc_t;

    // func3[1:0] is the access size: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data bus: byte enables and store replication on
// the way out, lane extract with sign/zero extension on the way back.
module lsu_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be        = 4'b1111;
        wdata_rep = wdata;
        load_ext  = rdata;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (func3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_ext  = func3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                load_ext  = func3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accept check in IDLE, req/gnt then rvalid handshake,
// pipeline stall while busy, and a per-phase timeout that aborts the access.
module lsu_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic        op_load;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] ld_q;

    logic        in_idle, access, illegal, misalign, accept, busy, timeout;
    logic [2:0]  la_f3;
    logic [1:0]  la_lo;
    logic [3:0]  la_be;
    logic [31:0] la_wdata, la_ext;
    lsu_exc_t    exc;

    // Reset gates the combinational decode so every output reads 0 while rst_n is low.
    assign in_idle  = rst_n && state == IDLE;
    assign access   = mem_read || mem_write;
    assign illegal  = (mem_read && mem_write)
                   || (mem_read && (func3 == 3'b011 || func3[2:1] == 2'b11))
                   || (mem_write && func3 > F3_SW);
    assign misalign = is_misaligned(func3[1:0], addr[1:0]);
    assign accept   = in_idle && access && !illegal && !misalign;
    assign busy     = state == REQ || state == WAIT;
    assign timeout  = busy && cnt == CW'(TIMEOUT);

    // One aligner serves both directions: live inputs during accept, registered op afterwards.
    assign la_f3 = (state == IDLE) ? func3 : f3_q;
    assign la_lo = (state == IDLE) ? addr[1:0] : lo_q;

    lsu_lane_align u_align (
        .func3     (la_f3),
        .addr_lo   (la_lo),
        .wdata     (wdata),
        .rdata     (dmem_rdata),
        .be        (la_be),
        .wdata_rep (la_wdata),
        .load_ext  (la_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_load <= 1'b0;
            f3_q    <= '0;
            lo_q    <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (state)
                IDLE: if (accept) begin
                    op_load <= mem_read;
                    f3_q    <= func3;
                    lo_q    <= addr[1:0];
                    be_q    <= la_be;
                    addr_q  <= {addr[31:2], 2'b00};
                    wdata_q <= la_wdata;
                    cnt     <= '0;
                    state   <= REQ;
                end
                REQ: begin
                    if (timeout) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (dmem_gnt) begin
                        cnt   <= '0;
                        state <= op_load ? WAIT : DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (dmem_rvalid) begin
                        ld_q  <= la_ext;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        exc = EXC_NONE;
        if (in_idle && access && illegal)       exc = EXC_ILLEGAL;
        else if (in_idle && access && misalign) exc = EXC_MISALIGN;
        else if (timeout)                       exc = EXC_TIMEOUT;
    end

    assign exc_valid  = exc != EXC_NONE;
    assign exc_cause  = exc;
    assign lsu_stall  = accept || (busy && !timeout);
    assign dmem_req   = state == REQ && !timeout;
    assign dmem_we    = dmem_req && !op_load;
    assign dmem_be    = dmem_req ? be_q : 4'b0000;
    assign dmem_addr  = dmem_req ? addr_q : 32'h0;
    assign dmem_wdata = dmem_req ? wdata_q : 32'h0;
    assign load_valid = state == DONE && op_load;
    assign load_data  = ld_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// against a behavioural model of the bus protocol and lane rules.
module tb_lsu_ctrl;
    import rv32_pkg::*;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        lsu_stall, load_valid, exc_valid, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [1:0]  exc_cause;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [106:0] all_out;

    int tests = 0;
    int fails = 0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall),
        .load_valid(load_valid), .load_data(load_data), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    assign all_out = {lsu_stall, load_valid, load_data, exc_valid, exc_cause, dmem_req,
                      dmem_we, dmem_be, dmem_addr, dmem_wdata};

    // Reference model: lane rules written as plain arithmetic on byte counts.
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
        int nb = 1 << f3[1:0];
        return 4'(((1 << nb) - 1) << lo);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'b00) return 32'(wd[7:0]) * 32'h01010101;
        if (f3[1:0] == 2'b01) return 32'(wd[15:0]) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rd);
        int nb = 1 << f3[1:0];
        longint unsigned v, mask;
        v    = 64'(rd) >> (8 * int'(lo));
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [1:0] m_cause(input bit mr, input bit mw, input logic [2:0] f3,
                                           input logic [1:0] lo);
        int nb = 1 << f3[1:0];
        if ((mr && mw) || (mr && (f3 == 3'd3 || f3 >= 3'd6)) || (mw && f3 > 3'd2)) return 2'b11;
        if (int'(lo) % nb != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drop_inputs();
        mem_read = 1'b0; mem_write = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    // Drives one access cycle by cycle; gd/rvd are the REQ/WAIT cycle index of gnt/rvalid.
    task automatic do_access(input bit mr, input bit mw, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int gd, input int rvd);
        logic [1:0] cause;
        bit         aborted = 0;
        cause = m_cause(mr, mw, f3, a[1:0]);
        @(posedge clk); #1;
        mem_read = mr; mem_write = mw; func3 = f3; addr = a; wdata = wd;
        dmem_gnt = 1'($urandom_range(0, 1)); dmem_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (cause != 2'b00) begin
            tests++;
            if ({exc_valid, exc_cause, lsu_stall, dmem_req} !== {1'b1, cause, 2'b00}) begin
                fails++;
                $display("FAIL accept_exc a=%h f3=%0d: got exc/cause/stall/req=%b want %b",
                         a, f3, {exc_valid, exc_cause, lsu_stall, dmem_req}, {1'b1, cause, 2'b00});
            end
            @(posedge clk); #1; drop_inputs();
            @(negedge clk);
            tests++;
            if ({dmem_req, lsu_stall, exc_valid} !== 3'b000) begin
                fails++;
                $display("FAIL after_exc: got req/stall/exc=%b want 000",
                         {dmem_req, lsu_stall, exc_valid});
            end
            return;
        end
        tests++;
        if ({lsu_stall, exc_valid, dmem_req} !== 3'b100) begin
            fails++;
            $display("FAIL accept a=%h: got stall/exc/req=%b want 100",
                     a, {lsu_stall, exc_valid, dmem_req});
        end
        for (int k = 0; k <= TO; k++) begin
            @(posedge clk); #1;
            dmem_gnt = (k == gd); dmem_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests++;
            if (k == TO) begin
                aborted = 1;
                if ({exc_valid, exc_cause, dmem_req, lsu_stall} !== 5'b11000) begin
                    fails++;
                    $display("FAIL req_timeout: got exc/cause/req/stall=%b want 11000",
                             {exc_valid, exc_cause, dmem_req, lsu_stall});
                end
                break;
            end
            if ({dmem_req, dmem_we, dmem_be, dmem_addr, lsu_stall, exc_valid} !==
                {1'b1, mw, m_be(f3, a[1:0]), a[31:2], 2'b00, 1'b1, 1'b0} ||
                (mw && dmem_wdata !== m_wd(f3, wd))) begin
                fails++;
                $display("FAIL req k=%0d: got req=%b we=%b be=%b addr=%h wd=%h stall=%b, want we=%b be=%b addr=%h wd=%h",
                         k, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, lsu_stall,
                         mw, m_be(f3, a[1:0]), {a[31:2], 2'b00}, m_wd(f3, wd));
            end
            if (k == gd) break;
        end
        if (mr && !aborted) begin
            for (int j = 0; j <= TO; j++) begin
                @(posedge clk); #1;
                dmem_gnt = 1'($urandom_range(0, 1)); dmem_rvalid = (j == rvd);
                dmem_rdata = (j == rvd) ? rd : $urandom;
                @(negedge clk);
                tests++;
                if (j == TO) begin
                    aborted = 1;
                    if ({exc_valid, exc_cause, dmem_req, lsu_stall, load_valid} !== 6'b110000) begin
                        fails++;
                        $display("FAIL wait_timeout: got exc/cause/req/stall/lv=%b want 110000",
                                 {exc_valid, exc_cause, dmem_req, lsu_stall, load_valid});
                    end
                    break;
                end
                if ({lsu_stall, dmem_req, exc_valid, load_valid} !== 4'b1000) begin
                    fails++;
                    $display("FAIL wait j=%0d: got stall/req/exc/lv=%b want 1000",
                             j, {lsu_stall, dmem_req, exc_valid, load_valid});
                end
                if (j == rvd) break;
            end
        end
        @(posedge clk); #1;
        drop_inputs(); dmem_rdata = $urandom;
        @(negedge clk);
        tests++;
        if (aborted) begin
            if ({lsu_stall, dmem_req, exc_valid, load_valid} !== 4'b0000) begin
                fails++;
                $display("FAIL post_timeout: got stall/req/exc/lv=%b want 0000",
                         {lsu_stall, dmem_req, exc_valid, load_valid});
            end
        end else if ({lsu_stall, dmem_req, exc_valid, load_valid} !== {3'b000, mr} ||
                     (mr && load_data !== m_load(f3, a[1:0], rd))) begin
            fails++;
            $display("FAIL done a=%h f3=%0d: got stall/req/exc/lv=%b data=%h want lv=%b data=%h",
                     a, f3, {lsu_stall, dmem_req, exc_valid, load_valid}, load_data,
                     mr, m_load(f3, a[1:0], rd));
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL idle_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_lw();
        do_access(1, 0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        tests++;
        if (load_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL lw_data: got %h want deadbeef", load_data);
        end
    endtask

    task automatic test_lb();
        do_access(1, 0, F3_LB, 32'h203, 32'h0, 32'h80FFFFFF, 0, 1);
        tests++;
        if (load_data !== 32'hFFFFFF80) begin
            fails++;
            $display("FAIL lb_data: got %h want ffffff80", load_data);
        end
        do_access(1, 0, F3_LBU, 32'h203, 32'h0, 32'h80FFFFFF, 1, 0);
        tests++;
        if (load_data !== 32'h00000080) begin
            fails++;
            $display("FAIL lbu_data: got %h want 00000080", load_data);
        end
    endtask

    task automatic test_sh();
        do_access(0, 1, F3_SH, 32'h302, 32'h1234ABCD, 32'h0, 3, 0);
        tests++;
        if (load_data !== 32'h00000080) begin
            fails++;
            $display("FAIL store_keeps_load_data: got %h want 00000080", load_data);
        end
    endtask

    task automatic test_exceptions();
        do_access(1, 0, F3_LW, 32'h101, 32'h0, 32'h0, 0, 0);
        do_access(1, 1, F3_LW, 32'h100, 32'h0, 32'h0, 0, 0);
        do_access(1, 0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, F3_LBU, 32'h100, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, F3_SH, 32'h103, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_timeout();
        do_access(1, 0, F3_LW, 32'h500, 32'h0, 32'h0, 0, NEVER);
        do_access(1, 0, F3_LW, 32'h504, 32'h0, 32'h0, NEVER, 0);
        do_access(0, 1, F3_SW, 32'h508, 32'h55, 32'h0, NEVER, 0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_read = 1'b1; func3 = F3_LW; addr = 32'h400;
        @(posedge clk); #1; dmem_gnt = 1'b1;
        @(posedge clk); #1; dmem_gnt = 1'b0;
        @(negedge clk);
        tests++;
        if ({lsu_stall, dmem_req} !== 2'b10) begin
            fails++;
            $display("FAIL reach_wait: got stall/req=%b want 10", {lsu_stall, dmem_req});
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_in_wait: got %h want 0", all_out);
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        @(posedge clk); #1; dmem_rvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({lsu_stall, load_valid, exc_valid, dmem_req, load_data} !== 36'h0) begin
            fails++;
            $display("FAIL late_rvalid: got stall/lv/exc/req=%b data=%h want 0",
                     {lsu_stall, load_valid, exc_valid, dmem_req}, load_data);
        end
        do_access(1, 0, F3_LW, 32'h404, 32'h0, 32'h13579BDF, 1, 2);
    endtask

    task automatic test_back_to_back();
        do_access(1, 0, F3_LH, 32'h602, 32'h0, 32'h9ABC1234, 0, 0);
        do_access(0, 1, F3_SB, 32'h601, 32'hA5A5A57E, 32'h0, 0, 0);
        tests++;
        if (load_data !== 32'hFFFF9ABC) begin
            fails++;
            $display("FAIL lh_hold: got %h want ffff9abc", load_data);
        end
        do_access(1, 0, F3_LHU, 32'h602, 32'h0, 32'h9ABC1234, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int  r  = $urandom_range(0, 9);
            bit  mr = (r < 5) || (r == 9);
            bit  mw = (r >= 5);
            logic [31:0] a = $urandom;
            int  gd  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 4);
            int  rvd = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 4);
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_access(mr, mw, f3, a, $urandom, $urandom, gd, rvd);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_exceptions();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
